// File: rtl/gpio_bank_ctrl.sv
// -----------------------------------------------------------------------------
// gpio_bank_ctrl
//
// GPIO controller for NUM_GPIO pins, organised as 32-bit register banks.
// Pad inputs are synchronised (2 flops), debounced per pin, and fed to
// per-pin rising/falling edge detectors that set sticky interrupt status.
//
// Register map per bank (reg_addr = {bank, index[2:0]}):
//   0 OUT (rw)   1 OE (rw)      2 IN (ro, debounced)   3 OUT_SET (wo)
//   4 OUT_CLR (wo) 5 RISE_EN (rw) 6 FALL_EN (rw)      7 IRQ_STATUS (r, W1C)
//
// Ports:
//   clk, rst_n       - clock, asynchronous active-low reset
//   reg_wr, reg_rd   - single-cycle write / read strobes
//   reg_addr         - {bank, index}
//   reg_wdata        - write data
//   reg_rdata        - registered read data, valid with reg_rvalid
//   reg_rvalid       - one-cycle read-data valid, cycle after reg_rd
//   gpio_in_data     - asynchronous pad inputs
//   gpio_out_data    - pad output values (OUT flops)
//   gpio_out_enable  - pad output enables (OE flops), 1 = drive
//   irq              - OR of all interrupt status bits
// -----------------------------------------------------------------------------
module gpio_bank_ctrl #(
   parameter int unsigned NUM_GPIO        = 64,
   parameter int unsigned DEBOUNCE_CYCLES = 4,
   parameter int unsigned ADDR_W          = $clog2((NUM_GPIO + 31) / 32) + 3
) (
   input  logic                clk,
   input  logic                rst_n,
   input  logic                reg_wr,
   input  logic                reg_rd,
   input  logic [ADDR_W-1:0]   reg_addr,
   input  logic [31:0]         reg_wdata,
   output logic [31:0]         reg_rdata,
   output logic                reg_rvalid,
   input  logic [NUM_GPIO-1:0] gpio_in_data,
   output logic [NUM_GPIO-1:0] gpio_out_data,
   output logic [NUM_GPIO-1:0] gpio_out_enable,
   output logic                irq
);

   localparam int unsigned NUM_BANKS = (NUM_GPIO + 31) / 32;
   localparam int unsigned PAD_W     = NUM_BANKS * 32;
   // 0 and 1 both mean "accept on the first mismatching cycle"
   localparam int unsigned WIN       = (DEBOUNCE_CYCLES > 1) ? DEBOUNCE_CYCLES : 1;
   localparam int unsigned CNT_W     = (DEBOUNCE_CYCLES > 0) ? $clog2(DEBOUNCE_CYCLES + 1) : 1;
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIN - 1);

   localparam logic [2:0] IDX_OUT     = 3'd0;
   localparam logic [2:0] IDX_OE      = 3'd1;
   localparam logic [2:0] IDX_IN      = 3'd2;
   localparam logic [2:0] IDX_OUT_SET = 3'd3;
   localparam logic [2:0] IDX_OUT_CLR = 3'd4;
   localparam logic [2:0] IDX_RISE_EN = 3'd5;
   localparam logic [2:0] IDX_FALL_EN = 3'd6;
   localparam logic [2:0] IDX_STATUS  = 3'd7;

   // ---------------------------------------------------------------------------
   // State
   // ---------------------------------------------------------------------------
   logic [NUM_GPIO-1:0] out_q, oe_q, rise_q, fall_q, status_q;
   logic [NUM_GPIO-1:0] out_n, oe_n, rise_n, fall_n, status_n;
   logic [NUM_GPIO-1:0] sync1_q, sync2_q;
   logic [NUM_GPIO-1:0] filt_q, filt_n;

   // ---------------------------------------------------------------------------
   // Address decode
   // ---------------------------------------------------------------------------
   logic [2:0]          idx;
   logic [31:0]         bank_idx;
   logic                bank_ok;
   logic [NUM_GPIO-1:0] wmask;   // pins belonging to the addressed bank
   logic [NUM_GPIO-1:0] wbits;   // write data aligned to pins, masked to bank

   assign idx = reg_addr[2:0];

   always_comb begin
      bank_idx = 32'(reg_addr) >> 3;
      bank_ok  = (bank_idx < NUM_BANKS);
   end

   // Pins at or above NUM_GPIO have no flops, so writes to them vanish here.
   always_comb begin
      wmask = '0;
      wbits = '0;
      for (int unsigned i = 0; i < NUM_GPIO; i++) begin
         wmask[i] = bank_ok && (bank_idx == (i / 32));
         wbits[i] = wmask[i] & reg_wdata[i % 32];
      end
   end

   // ---------------------------------------------------------------------------
   // Register next-state
   // ---------------------------------------------------------------------------
   always_comb begin
      out_n  = out_q;
      oe_n   = oe_q;
      rise_n = rise_q;
      fall_n = fall_q;
      if (reg_wr) begin
         case (idx)
            IDX_OUT:     out_n  = (out_q  & ~wmask) | wbits;
            IDX_OE:      oe_n   = (oe_q   & ~wmask) | wbits;
            IDX_OUT_SET: out_n  = out_q | wbits;
            IDX_OUT_CLR: out_n  = out_q & ~wbits;
            IDX_RISE_EN: rise_n = (rise_q & ~wmask) | wbits;
            IDX_FALL_EN: fall_n = (fall_q & ~wmask) | wbits;
            default: ;
         endcase
      end
   end

   // W1C is applied first and new edge events are OR-ed in afterwards, so a
   // coincident event keeps its status bit set.
   always_comb begin
      status_n = status_q;
      if (reg_wr && (idx == IDX_STATUS)) begin
         status_n = status_q & ~wbits;
      end
      status_n = status_n
               | (rise_q & ~filt_q &  filt_n)
               | (fall_q &  filt_q & ~filt_n);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         out_q    <= '0;
         oe_q     <= '0;
         rise_q   <= '0;
         fall_q   <= '0;
         status_q <= '0;
      end else begin
         out_q    <= out_n;
         oe_q     <= oe_n;
         rise_q   <= rise_n;
         fall_q   <= fall_n;
         status_q <= status_n;
      end
   end

   // ---------------------------------------------------------------------------
   // Input synchroniser and debounce
   // ---------------------------------------------------------------------------
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         sync1_q <= '0;
         sync2_q <= '0;
         filt_q  <= '0;
      end else begin
         sync1_q <= gpio_in_data;
         sync2_q <= sync1_q;
         filt_q  <= filt_n;
      end
   end

   for (genvar i = 0; i < NUM_GPIO; i++) begin : g_deb
      logic [CNT_W-1:0] cnt;

      // Accept the synchronised value once it has differed from filt for a
      // full window; any cycle of agreement restarts the count.
      assign filt_n[i] = ((sync2_q[i] != filt_q[i]) && (cnt == CNT_LAST))
                         ? sync2_q[i] : filt_q[i];

      always_ff @(posedge clk or negedge rst_n) begin
         if (!rst_n) begin
            cnt <= '0;
         end else if (sync2_q[i] == filt_q[i]) begin
            cnt <= '0;
         end else if (cnt == CNT_LAST) begin
            cnt <= '0;
         end else begin
            cnt <= cnt + CNT_W'(1);
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Read path
   // ---------------------------------------------------------------------------
   logic [PAD_W-1:0] out_pad, oe_pad, in_pad, rise_pad, fall_pad, status_pad;
   logic [PAD_W-1:0] sel_pad;
   logic [31:0]      rd_word;

   assign out_pad    = PAD_W'(out_q);
   assign oe_pad     = PAD_W'(oe_q);
   assign in_pad     = PAD_W'(filt_q);
   assign rise_pad   = PAD_W'(rise_q);
   assign fall_pad   = PAD_W'(fall_q);
   assign status_pad = PAD_W'(status_q);

   always_comb begin
      case (idx)
         IDX_OUT:     sel_pad = out_pad;
         IDX_OE:      sel_pad = oe_pad;
         IDX_IN:      sel_pad = in_pad;
         IDX_RISE_EN: sel_pad = rise_pad;
         IDX_FALL_EN: sel_pad = fall_pad;
         IDX_STATUS:  sel_pad = status_pad;
         default:     sel_pad = '0;   // OUT_SET / OUT_CLR are write-only
      endcase
   end

   always_comb begin
      rd_word = '0;
      for (int unsigned b = 0; b < NUM_BANKS; b++) begin
         if (bank_ok && (bank_idx == b)) begin
            rd_word = sel_pad[b*32 +: 32];
         end
      end
   end

   // Read data is captured from the current flops, so a same-cycle write to
   // the same address is observed only by later reads.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         reg_rdata  <= '0;
         reg_rvalid <= 1'b0;
      end else begin
         reg_rvalid <= reg_rd;
         if (reg_rd) begin
            reg_rdata <= rd_word;
         end
      end
   end

   // ---------------------------------------------------------------------------
   // Outputs
   // ---------------------------------------------------------------------------
   assign gpio_out_data   = out_q;
   assign gpio_out_enable = oe_q;
   assign irq             = |status_q;

endmodule

// File: tb/tb_gpio_bank_ctrl.sv
// -----------------------------------------------------------------------------
// tb_gpio_bank_ctrl
//
// Scoreboard bench for gpio_bank_ctrl with 48 pins (two banks, the upper one
// 16 bits wide), a 4-cycle debounce window and a 5-bit address so that
// out-of-range banks 2 and 3 are addressable. Register state is modelled as
// per-bank 32-bit words; debounced inputs are modelled as "settled pin value"
// once an input change has been held for the full latency.
// -----------------------------------------------------------------------------
module tb_gpio_bank_ctrl;

   localparam int NG     = 48;
   localparam int D      = 4;
   localparam int AW     = 5;
   localparam int SETTLE = 2 + D;   // edges from input change to filt/status

   logic          clk = 1'b0;
   logic          rst_n;
   logic          reg_wr, reg_rd;
   logic [AW-1:0] reg_addr;
   logic [31:0]   reg_wdata;
   logic [31:0]   reg_rdata;
   logic          reg_rvalid;
   logic [NG-1:0] gpio_in_data;
   logic [NG-1:0] gpio_out_data;
   logic [NG-1:0] gpio_out_enable;
   logic          irq;

   gpio_bank_ctrl #(
      .NUM_GPIO        (NG),
      .DEBOUNCE_CYCLES (D),
      .ADDR_W          (AW)
   ) dut (
      .clk             (clk),
      .rst_n           (rst_n),
      .reg_wr          (reg_wr),
      .reg_rd          (reg_rd),
      .reg_addr        (reg_addr),
      .reg_wdata       (reg_wdata),
      .reg_rdata       (reg_rdata),
      .reg_rvalid      (reg_rvalid),
      .gpio_in_data    (gpio_in_data),
      .gpio_out_data   (gpio_out_data),
      .gpio_out_enable (gpio_out_enable),
      .irq             (irq)
   );

   always #5 clk = ~clk;

   int n_cmp = 0;
   int n_bad = 0;
   logic [31:0] exp_q[$];

   // Reference model, one 32-bit word per bank
   logic [31:0] m_out[2], m_oe[2], m_rise[2], m_fall[2], m_st[2], m_filt[2];
   logic [31:0] vmask[2];

   task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
      n_cmp++;
      if (act !== exp) begin
         n_bad++;
         $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   function automatic logic [AW-1:0] A(input int bank, input int idx);
      logic [4:0] a;
      a = {2'(bank), 3'(idx)};
      return a;
   endfunction

   task automatic model_reset();
      for (int b = 0; b < 2; b++) begin
         m_out[b] = '0; m_oe[b] = '0; m_rise[b] = '0;
         m_fall[b] = '0; m_st[b] = '0; m_filt[b] = '0;
      end
   endtask

   function automatic logic [31:0] model_read(input logic [AW-1:0] a);
      int b;
      b = int'(a[4:3]);
      if (b >= 2) return 32'h0;
      case (a[2:0])
         3'd0: return m_out[b];
         3'd1: return m_oe[b];
         3'd2: return m_filt[b];
         3'd5: return m_rise[b];
         3'd6: return m_fall[b];
         3'd7: return m_st[b];
         default: return 32'h0;
      endcase
   endfunction

   task automatic model_write(input logic [AW-1:0] a, input logic [31:0] d);
      int b;
      logic [31:0] dm;
      b = int'(a[4:3]);
      if (b >= 2) return;
      dm = d & vmask[b];
      case (a[2:0])
         3'd0: m_out[b]  = dm;
         3'd1: m_oe[b]   = dm;
         3'd3: m_out[b]  = m_out[b] | dm;
         3'd4: m_out[b]  = m_out[b] & ~dm;
         3'd5: m_rise[b] = dm;
         3'd6: m_fall[b] = dm;
         3'd7: m_st[b]   = m_st[b] & ~dm;
         default: ;
      endcase
   endtask

   // Debounced inputs have settled to v: record edges against the enables.
   task automatic model_pins(input logic [NG-1:0] v);
      logic [31:0] nv[2];
      nv[0] = v[31:0];
      nv[1] = {16'h0, v[47:32]};
      for (int b = 0; b < 2; b++) begin
         m_st[b]   = m_st[b] | (m_rise[b] & ~m_filt[b] & nv[b])
                             | (m_fall[b] & m_filt[b] & ~nv[b]);
         m_filt[b] = nv[b];
      end
   endtask

   task automatic check_outs();
      check("gpio_out_data",   gpio_out_data,   {m_out[1][15:0], m_out[0]});
      check("gpio_out_enable", gpio_out_enable, {m_oe[1][15:0],  m_oe[0]});
      check("irq",             irq,             (|m_st[0]) || (|m_st[1]));
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic wr(input logic [AW-1:0] a, input logic [31:0] d);
      reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      tick();
      reg_wr = 1'b0;
      model_write(a, d);
      check_outs();
   endtask

   task automatic rd(input logic [AW-1:0] a);
      reg_rd = 1'b1; reg_addr = a;
      exp_q.push_back(model_read(a));
      tick();
      reg_rd = 1'b0;
   endtask

   task automatic rdwr(input logic [AW-1:0] a, input logic [31:0] d);
      reg_rd = 1'b1; reg_wr = 1'b1; reg_addr = a; reg_wdata = d;
      exp_q.push_back(model_read(a));
      tick();
      reg_rd = 1'b0; reg_wr = 1'b0;
      model_write(a, d);
      check_outs();
   endtask

   task automatic set_pins(input logic [NG-1:0] v);
      gpio_in_data = v;
      repeat (SETTLE) tick();
      model_pins(v);
      check_outs();
   endtask

   // Bank-0 pin p rises and is held: irq must still be low one edge before
   // the end of the latency and high exactly at it.
   task automatic rise_latency(input int p);
      logic [NG-1:0] v;
      v = gpio_in_data;
      v[p] = 1'b1;
      gpio_in_data = v;
      repeat (SETTLE - 1) tick();
      check("irq_before_window", irq, 1'b0);
      tick();
      check("irq_at_window", irq, 1'b1);
      model_pins(v);
   endtask

   // Monitor: every reg_rvalid pops one expected read value.
   initial begin
      forever begin
         @(negedge clk);
         if (reg_rvalid) begin
            if (exp_q.size() == 0) begin
               check("unexpected_rvalid", 1'b1, 1'b0);
            end else begin
               check("reg_rdata", reg_rdata, exp_q.pop_front());
            end
         end
      end
   end

   initial begin
      #500us;
      $display("FAIL watchdog: simulation time limit reached");
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad + 1);
      $fatal(1, "watchdog");
   end

   initial begin
      logic [63:0] r64;
      logic [NG-1:0] v;
      logic [AW-1:0] a;
      logic [31:0] d;
      int op;

      vmask[0] = 32'hFFFF_FFFF;
      vmask[1] = 32'h0000_FFFF;
      model_reset();
      rst_n = 1'b0;
      reg_wr = 1'b0; reg_rd = 1'b0; reg_addr = '0; reg_wdata = '0;
      gpio_in_data = '1;

      // Reset state with all pads high
      repeat (3) @(posedge clk);
      #1;
      check_outs();
      check("rst_rvalid", reg_rvalid, 1'b0);
      check("rst_rdata",  reg_rdata,  32'h0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (SETTLE + 1) tick();
      model_pins('1);
      check_outs();
      rd(A(0, 2));
      rd(A(1, 2));
      rd(A(0, 7));
      rd(A(1, 7));

      // OUT / OUT_SET / OUT_CLR
      wr(A(0, 0), 32'h0000_00F0);
      wr(A(0, 3), 32'h0000_0001);
      wr(A(0, 4), 32'h0000_0010);
      check("out_low_word", gpio_out_data[31:0], 32'hE1);
      rd(A(0, 3));
      rd(A(0, 0));
      rd(A(0, 4));

      // Rising edge on pin 3: exact latency, then W1C, then a short pulse
      set_pins('0);
      wr(A(0, 5), 32'h8);
      rise_latency(3);
      check_outs();
      rd(A(0, 7));
      wr(A(0, 7), 32'h8);
      set_pins('0);
      v = '0; v[3] = 1'b1;
      gpio_in_data = v;
      repeat (3) tick();
      gpio_in_data = '0;
      repeat (SETTLE + 2) tick();
      check_outs();
      rd(A(0, 2));
      rd(A(0, 7));

      // Falling edge on pin 40 (bank 1 bit 8), W1C, coincident W1C
      v = '0; v[40] = 1'b1;
      set_pins(v);
      wr(A(1, 6), 32'h100);
      set_pins('0);
      rd(A(1, 7));
      wr(A(1, 7), 32'h100);
      set_pins(v);
      gpio_in_data = '0;
      repeat (SETTLE - 1) tick();
      reg_wr = 1'b1; reg_addr = A(1, 7); reg_wdata = 32'h100;
      tick();
      reg_wr = 1'b0;
      model_write(A(1, 7), 32'h100);
      model_pins('0);
      check_outs();
      rd(A(1, 7));
      rd(A(1, 6));

      // Partial top bank and out-of-range banks
      wr(A(1, 0), 32'hFFFF_FFFF);
      rd(A(1, 0));
      wr(A(2, 0), 32'hFFFF_FFFF);
      wr(A(3, 1), 32'hFFFF_FFFF);
      rd(A(2, 2));
      rd(A(3, 0));
      rd(A(2, 7));

      // Same-cycle read and write to one address returns the old value
      rdwr(A(0, 0), 32'h1234_5678);
      rd(A(0, 0));

      // Randomised register traffic and input changes
      for (int it = 0; it < 150; it++) begin
         op = int'($urandom_range(0, 9));
         a  = AW'($urandom_range(0, 31));
         d  = $urandom;
         if (op <= 3) begin
            wr(a, d);
         end else if (op <= 6) begin
            rd(a);
         end else if (op == 7) begin
            rdwr(a, d);
         end else begin
            r64 = {$urandom, $urandom};
            set_pins(r64[NG-1:0]);
         end
      end

      // Reset in the middle of a debounce count
      wr(A(0, 5), 32'hFFFF_FFFF);
      wr(A(0, 1), 32'h0000_FFFF);
      set_pins('0);
      v = '0; v[3] = 1'b1;
      gpio_in_data = v;
      repeat (3) tick();
      #2;
      rst_n = 1'b0;
      #1;
      model_reset();
      check_outs();
      check("rst_mid_rvalid", reg_rvalid, 1'b0);
      gpio_in_data = '0;
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      tick();
      wr(A(0, 5), 32'h8);
      rise_latency(3);
      check_outs();
      rd(A(0, 7));
      rd(A(0, 2));

      repeat (3) tick();
      check("pending_reads", exp_q.size(), 0);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
      $finish;
   end

endmodule
